// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the on-chip slave bus between the fetch and data
// ports of the core, granting round-robin with one access in flight.
//
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   imem_*                 fetch master: valid/addr in, ready/rdata/error out
//   dmem_*                 data master: valid/addr/wdata/wstrb in,
//                          ready/rdata/error out
//   slv_addr/wdata/wstrb   request fields latched at grant, shared by slaves
//   slv_instr              1 when the current access came from the fetch port
//   <s>_valid/ready/rdata  per-slave handshake for rom, uart, clint, axi
//
// Every output comes straight from a flop.
module mem_bus_arbiter #(
    parameter logic [31:0] rom_base   = 32'h0000_0000,
    parameter logic [31:0] rom_top    = 32'h0000_0080,
    parameter logic [31:0] uart_base  = 32'h0100_0000,
    parameter logic [31:0] uart_top   = 32'h0100_0004,
    parameter logic [31:0] clint_base = 32'h0200_0000,
    parameter logic [31:0] clint_top  = 32'h0200_C000,
    parameter logic [31:0] axi_base   = 32'h8000_0000,
    parameter logic [31:0] axi_top    = 32'h9000_0000
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_error,

    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,

    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    output logic        slv_instr,

    output logic        rom_valid,
    output logic        uart_valid,
    output logic        clint_valid,
    output logic        axi_valid,

    input  logic        rom_ready,
    input  logic        uart_ready,
    input  logic        clint_ready,
    input  logic        axi_ready,

    input  logic [31:0] rom_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] clint_rdata,
    input  logic [31:0] axi_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERROR,
        DONE
    } state_e;

    // One-hot slave select, bit order {axi, clint, uart, rom}.
    state_e      state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        gnt_data_q, gnt_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic [3:0]  sel_q, sel_d;

    logic        imem_ready_q, imem_ready_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic        imem_error_q, imem_error_d;
    logic        dmem_ready_q, dmem_ready_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        dmem_error_q, dmem_error_d;

    logic        pick_data;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [3:0]  slv_ready;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        finish;
    logic [31:0] fin_rdata;
    logic        fin_error;

    // Single unsigned compare covers base <= a < top, and stays
    // meaningful when base is zero.
    function automatic logic in_region(
        input logic [31:0] a,
        input logic [31:0] base,
        input logic [31:0] top
    );
        return (a - base) < (top - base);
    endfunction

    // Data wins only when fetch is idle or fetch had the last grant.
    always_comb begin
        pick_data = dmem_valid & (~imem_valid | ~last_data_q);
        req_addr  = pick_data ? dmem_addr : imem_addr;
        req_sel   = {
            in_region(req_addr, axi_base, axi_top),
            in_region(req_addr, clint_base, clint_top),
            in_region(req_addr, uart_base, uart_top),
            in_region(req_addr, rom_base, rom_top)
        };
    end

    assign slv_ready = {axi_ready, clint_ready, uart_ready, rom_ready};

    // Only the selected slave's ready counts.
    assign sel_ready = |(sel_q & slv_ready);

    assign sel_rdata = ({32{sel_q[0]}} & rom_rdata)
                     | ({32{sel_q[1]}} & uart_rdata)
                     | ({32{sel_q[2]}} & clint_rdata)
                     | ({32{sel_q[3]}} & axi_rdata);

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        gnt_data_d   = gnt_data_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        instr_d      = instr_q;
        sel_d        = sel_q;
        imem_ready_d = 1'b0;
        imem_rdata_d = 32'h0;
        imem_error_d = 1'b0;
        dmem_ready_d = 1'b0;
        dmem_rdata_d = 32'h0;
        dmem_error_d = 1'b0;
        finish       = 1'b0;
        fin_rdata    = 32'h0;
        fin_error    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (imem_valid | dmem_valid) begin
                    last_data_d = pick_data;
                    gnt_data_d  = pick_data;
                    addr_d      = req_addr;
                    wdata_d     = pick_data ? dmem_wdata : 32'h0;
                    wstrb_d     = pick_data ? dmem_wstrb : 4'h0;
                    instr_d     = ~pick_data;
                    sel_d       = req_sel;
                    state_d     = (|req_sel) ? ACCESS : ERROR;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    sel_d     = 4'h0;
                    finish    = 1'b1;
                    fin_rdata = sel_rdata;
                    state_d   = DONE;
                end
            end
            ERROR: begin
                finish    = 1'b1;
                fin_error = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response flops load on entry to DONE and clear on exit,
        // giving a single-cycle ready pulse to the granted master.
        if (finish) begin
            if (gnt_data_q) begin
                dmem_ready_d = 1'b1;
                dmem_rdata_d = fin_rdata;
                dmem_error_d = fin_error;
            end else begin
                imem_ready_d = 1'b1;
                imem_rdata_d = fin_rdata;
                imem_error_d = fin_error;
            end
        end
    end

    // last_data resets to 1 so that fetch wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b1;
            gnt_data_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            instr_q      <= 1'b0;
            sel_q        <= 4'h0;
            imem_ready_q <= 1'b0;
            imem_rdata_q <= 32'h0;
            imem_error_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            dmem_rdata_q <= 32'h0;
            dmem_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            gnt_data_q   <= gnt_data_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            instr_q      <= instr_d;
            sel_q        <= sel_d;
            imem_ready_q <= imem_ready_d;
            imem_rdata_q <= imem_rdata_d;
            imem_error_q <= imem_error_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_error_q <= dmem_error_d;
        end
    end

    assign imem_ready  = imem_ready_q;
    assign imem_rdata  = imem_rdata_q;
    assign imem_error  = imem_error_q;
    assign dmem_ready  = dmem_ready_q;
    assign dmem_rdata  = dmem_rdata_q;
    assign dmem_error  = dmem_error_q;

    assign slv_addr    = addr_q;
    assign slv_wdata   = wdata_q;
    assign slv_wstrb   = wstrb_q;
    assign slv_instr   = instr_q;

    assign rom_valid   = sel_q[0];
    assign uart_valid  = sel_q[1];
    assign clint_valid = sel_q[2];
    assign axi_valid   = sel_q[3];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random two-master traffic against a transaction-level
// model of the arbiter, plus reset and stalled-access scenarios.
module tb_mem_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;

    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_error;

    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        slv_instr;

    logic        rom_valid, uart_valid, clint_valid, axi_valid;
    logic        rom_ready, uart_ready, clint_ready, axi_ready;
    logic [31:0] rom_rdata, uart_rdata, clint_rdata, axi_rdata;

    mem_bus_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .imem_valid  (imem_valid),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .imem_error  (imem_error),
        .dmem_valid  (dmem_valid),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .dmem_error  (dmem_error),
        .slv_addr    (slv_addr),
        .slv_wdata   (slv_wdata),
        .slv_wstrb   (slv_wstrb),
        .slv_instr   (slv_instr),
        .rom_valid   (rom_valid),
        .uart_valid  (uart_valid),
        .clint_valid (clint_valid),
        .axi_valid   (axi_valid),
        .rom_ready   (rom_ready),
        .uart_ready  (uart_ready),
        .clint_ready (clint_ready),
        .axi_ready   (axi_ready),
        .rom_rdata   (rom_rdata),
        .uart_rdata  (uart_rdata),
        .clint_rdata (clint_rdata),
        .axi_rdata   (axi_rdata)
    );

    always #5 clock = ~clock;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory map, index 0..3 = rom, uart, clint, axi.
    logic [31:0] r_base [4] = '{32'h0000_0000, 32'h0100_0000,
                                32'h0200_0000, 32'h8000_0000};
    logic [31:0] r_top  [4] = '{32'h0000_0080, 32'h0100_0004,
                                32'h0200_C000, 32'h9000_0000};

    function automatic int region_of(input logic [31:0] a);
        for (int r = 0; r < 4; r++)
            if (a >= r_base[r] && a < r_top[r]) return r;
        return -1;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] pool [14] = '{
            32'h0000_0000, 32'h0000_0010, 32'h0000_0040, 32'h0000_007C,
            32'h0000_0080, 32'h0100_0000, 32'h0100_0004, 32'h0200_0000,
            32'h0200_BFFC, 32'h0200_C000, 32'h7FFF_FFFC, 32'h8000_0000,
            32'h8FFF_FFFC, 32'h9000_0000};
        logic [31:0] span;
        int r;
        case ($urandom_range(0, 2))
            0: return pool[$urandom_range(0, 13)];
            1: begin
                r = $urandom_range(0, 3);
                span = r_top[r] - r_base[r];
                return r_base[r] + (($urandom % span) & 32'hFFFF_FFFC);
            end
            default: return $urandom;
        endcase
    endfunction

    // Model state: one transaction record plus timing.
    int          cyc, t_gnt, t_rdy, t_done;
    bit          any_gnt, last_data, m_data, m_err;
    bit          quiet, hold;
    int          m_slave;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    int          i_gap, d_gap;

    task automatic randomize_inputs();
        imem_valid  = 1'($urandom);
        imem_addr   = $urandom;
        dmem_valid  = 1'($urandom);
        dmem_addr   = $urandom;
        dmem_wdata  = $urandom;
        dmem_wstrb  = 4'($urandom);
        rom_ready   = 1'($urandom);
        uart_ready  = 1'($urandom);
        clint_ready = 1'($urandom);
        axi_ready   = 1'($urandom);
        rom_rdata   = $urandom;
        uart_rdata  = $urandom;
        clint_rdata = $urandom;
        axi_rdata   = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 160'({imem_ready, imem_rdata, imem_error,
                         dmem_ready, dmem_rdata, dmem_error,
                         slv_addr, slv_wdata, slv_wstrb, slv_instr,
                         rom_valid, uart_valid, clint_valid, axi_valid}),
              160'h0);
    endtask

    task automatic set_slave(input int s, input logic rdy,
                             output logic [31:0] rd);
        case (s)
            0: begin rom_ready = rdy;   rd = rom_rdata;   end
            1: begin uart_ready = rdy;  rd = uart_rdata;  end
            2: begin clint_ready = rdy; rd = clint_rdata; end
            default: begin axi_ready = rdy; rd = axi_rdata; end
        endcase
    endtask

    task automatic observe();
        logic [3:0]  ev;
        logic [33:0] ei, ed;
        @(posedge clock);
        #1;
        cyc++;
        ev = 4'h0;
        if (any_gnt && m_slave >= 0 && cyc > t_gnt && cyc < t_done)
            ev = 4'h1 << m_slave;
        ei = '0;
        ed = '0;
        if (any_gnt && cyc == t_done) begin
            if (m_data) ed = {1'b1, m_rdata, m_err};
            else        ei = {1'b1, m_rdata, m_err};
        end
        check("slv_valid",
              160'({axi_valid, clint_valid, uart_valid, rom_valid}),
              160'(ev));
        check("imem_rsp", 160'({imem_ready, imem_rdata, imem_error}),
              160'(ei));
        check("dmem_rsp", 160'({dmem_ready, dmem_rdata, dmem_error}),
              160'(ed));
        if (!any_gnt)
            check("slv_bus_reset",
                  160'({slv_addr, slv_wdata, slv_wstrb, slv_instr}), 160'h0);
        else if (cyc > t_gnt)
            check("slv_bus",
                  160'({slv_addr, slv_wdata, slv_wstrb, slv_instr}),
                  160'({m_addr, m_wdata, m_wstrb, ~m_data}));
    endtask

    task automatic drive();
        bit          served_i, served_d;
        logic [31:0] rd;
        int          sd;

        served_i = any_gnt && cyc == t_done + 1 && !m_data;
        served_d = any_gnt && cyc == t_done + 1 && m_data;

        if (served_i) begin
            imem_valid = 1'b0;
            i_gap = $urandom_range(0, 3);
        end else if (!imem_valid && !quiet) begin
            if (i_gap == 0) begin
                imem_valid = 1'b1;
                imem_addr  = pick_addr();
            end else begin
                i_gap--;
            end
        end

        if (served_d) begin
            dmem_valid = 1'b0;
            d_gap = $urandom_range(0, 3);
        end else if (!dmem_valid && !quiet) begin
            if (d_gap == 0) begin
                dmem_valid = 1'b1;
                dmem_addr  = pick_addr();
                dmem_wdata = $urandom;
                dmem_wstrb = $urandom_range(0, 1) ? 4'h0
                                                  : 4'($urandom_range(1, 15));
            end else begin
                d_gap--;
            end
        end

        // Unselected slaves chatter on ready; the selected one answers
        // only at its scheduled cycle.
        rom_ready   = ($urandom_range(0, 3) == 0);
        uart_ready  = ($urandom_range(0, 3) == 0);
        clint_ready = ($urandom_range(0, 3) == 0);
        axi_ready   = ($urandom_range(0, 3) == 0);
        rom_rdata   = $urandom;
        uart_rdata  = $urandom;
        clint_rdata = $urandom;
        axi_rdata   = $urandom;
        if (any_gnt && m_slave >= 0 && cyc > t_gnt && cyc <= t_rdy) begin
            set_slave(m_slave, cyc == t_rdy, rd);
            if (cyc == t_rdy) m_rdata = rd;
        end

        // Arbitration at the end of an idle cycle.
        if ((!any_gnt || cyc > t_done) && (imem_valid || dmem_valid)) begin
            m_data    = (imem_valid && dmem_valid) ? !last_data : dmem_valid;
            last_data = m_data;
            any_gnt   = 1'b1;
            t_gnt     = cyc;
            m_addr    = m_data ? dmem_addr : imem_addr;
            m_wdata   = m_data ? dmem_wdata : 32'h0;
            m_wstrb   = m_data ? dmem_wstrb : 4'h0;
            m_slave   = region_of(m_addr);
            m_rdata   = 32'h0;
            if (m_slave < 0) begin
                m_err  = 1'b1;
                t_rdy  = -1;
                t_done = cyc + 2;
            end else begin
                m_err  = 1'b0;
                sd     = hold ? 10000 : $urandom_range(0, 4);
                t_rdy  = cyc + 1 + sd;
                t_done = t_rdy + 1;
            end
        end
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset     = 1'b0;
        cyc       = 0;
        any_gnt   = 1'b0;
        last_data = 1'b1;
        t_gnt     = -1;
        t_rdy     = -1;
        t_done    = -1;
        m_slave   = -1;
        drive();
    endtask

    initial begin
        bit ok;
        reset = 1'b1;
        quiet = 1'b1;
        hold  = 1'b0;
        i_gap = 0;
        d_gap = 0;
        randomize_inputs();
        repeat (4) begin
            @(posedge clock);
            #1;
            randomize_inputs();
            check_all_zero("reset_outputs");
        end

        // Idle bus after release.
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        release_reset();
        repeat (6) begin
            observe();
            drive();
        end

        quiet = 1'b0;
        repeat (3000) begin
            observe();
            drive();
        end

        // Drain to an idle bus.
        quiet = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            observe();
            drive();
            if (!imem_valid && !dmem_valid && cyc > t_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 160'(ok), 160'h1);

        // AXI access that never completes, then reset mid-cycle.
        observe();
        dmem_valid = 1'b1;
        dmem_addr  = 32'h8000_0100;
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'h0;
        hold = 1'b1;
        drive();
        repeat (21) begin
            observe();
            drive();
        end
        check("axi_stall_valid", 160'(axi_valid), 160'h1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");

        hold       = 1'b0;
        dmem_valid = 1'b0;
        imem_valid = 1'b1;
        imem_addr  = 32'h0;
        @(posedge clock);
        #1;
        check_all_zero("reset_held");
        release_reset();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            observe();
            drive();
            if (any_gnt && cyc > t_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("fetch0_done", 160'(ok), 160'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
